// File: rtl/csr_trap_seq_if.sv
// Bundle between the M stage / CSR file and the trap sequencer.
// The master side is the pipeline and CSR file; the slave side is the sequencer.
interface csr_trap_seq_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_i;
  logic            exc_req_i;
  logic [3:0]      exc_cause_i;
  logic            irq_i;
  logic            mret_i;
  logic            pipe_we_i;
  logic [11:0]     pipe_idx_i;
  logic [XLEN-1:0] pipe_wdat_i;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  logic            csr_we_o;
  logic [11:0]     csr_idx_o;
  logic [XLEN-1:0] csr_wdat_o;
  logic            stall_o;
  logic            flush_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output pc_i, exc_req_i, exc_cause_i, irq_i, mret_i,
           pipe_we_i, pipe_idx_i, pipe_wdat_i, mstatus_i, mtvec_i, mepc_i,
    input  csr_we_o, csr_idx_o, csr_wdat_o, stall_o, flush_o,
           redirect_o, redirect_pc_o
  );

  modport slave (
    input  pc_i, exc_req_i, exc_cause_i, irq_i, mret_i,
           pipe_we_i, pipe_idx_i, pipe_wdat_i, mstatus_i, mtvec_i, mepc_i,
    output csr_we_o, csr_idx_o, csr_wdat_o, stall_o, flush_o,
           redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_trap_seq.sv
// Trap/MRET sequencer: serialises mepc/mcause/mstatus updates through the single
// CSR write port, then redirects fetch; forwards pipeline CSR writes while idle.
module csr_trap_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] IRQ_CODE = XLEN'(11)
) (
  input  logic           clk,
  input  logic           reset,
  csr_trap_seq_if.slave  bus
);

  localparam logic [11:0] IDX_MSTATUS = 12'h300;
  localparam logic [11:0] IDX_MEPC    = 12'h341;
  localparam logic [11:0] IDX_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_STAT, MRET_ST, REDIR
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, cause_q;
  logic            mret_q;

  logic            idle, take_exc, take_irq, take_trap, take_mret;
  logic [XLEN-1:0] exc_cause_val, irq_cause_val;
  logic [XLEN-1:0] stat_trap, stat_mret;

  logic            we, stall, flush, redir;
  logic [11:0]     idx;
  logic [XLEN-1:0] wdat, rpc;

  // Gating with reset keeps every output at 0 for as long as reset is held.
  assign idle      = (state_q == IDLE) && !reset;
  assign take_exc  = idle && bus.exc_req_i;
  assign take_irq  = idle && !bus.exc_req_i && bus.irq_i && bus.mstatus_i[3];
  assign take_trap = take_exc || take_irq;
  assign take_mret = idle && !take_trap && bus.mret_i;

  assign exc_cause_val = {{(XLEN-4){1'b0}}, bus.exc_cause_i};
  assign irq_cause_val = {1'b1, IRQ_CODE[XLEN-2:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_trap) begin
        pc_q    <= bus.pc_i;
        cause_q <= take_exc ? exc_cause_val : irq_cause_val;
        mret_q  <= 1'b0;
      end else if (take_mret) begin
        mret_q  <= 1'b1;
      end
    end
  end

  // mstatus images for trap entry and MRET, built from the live CSR value.
  always_comb begin
    stat_trap        = bus.mstatus_i;
    stat_trap[7]     = bus.mstatus_i[3];
    stat_trap[3]     = 1'b0;
    stat_trap[12:11] = 2'b11;
    stat_mret        = bus.mstatus_i;
    stat_mret[3]     = bus.mstatus_i[7];
    stat_mret[7]     = 1'b1;
    stat_mret[12:11] = 2'b11;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    idx     = '0;
    wdat    = '0;
    stall   = 1'b0;
    flush   = 1'b0;
    redir   = 1'b0;
    rpc     = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (take_trap) begin
            stall   = 1'b1;
            flush   = 1'b1;
            state_d = W_EPC;
          end else if (take_mret) begin
            stall   = 1'b1;
            flush   = 1'b1;
            state_d = MRET_ST;
          end else if (bus.pipe_we_i) begin
            we   = 1'b1;
            idx  = bus.pipe_idx_i;
            wdat = bus.pipe_wdat_i;
          end
        end
        W_EPC: begin
          stall   = 1'b1;
          we      = 1'b1;
          idx     = IDX_MEPC;
          wdat    = pc_q & ~XLEN'(1);
          state_d = W_CAUSE;
        end
        W_CAUSE: begin
          stall   = 1'b1;
          we      = 1'b1;
          idx     = IDX_MCAUSE;
          wdat    = cause_q;
          state_d = W_STAT;
        end
        W_STAT: begin
          stall   = 1'b1;
          we      = 1'b1;
          idx     = IDX_MSTATUS;
          wdat    = stat_trap;
          state_d = REDIR;
        end
        MRET_ST: begin
          stall   = 1'b1;
          we      = 1'b1;
          idx     = IDX_MSTATUS;
          wdat    = stat_mret;
          state_d = REDIR;
        end
        REDIR: begin
          // Target is read here so it reflects any CSR write issued just before.
          stall   = 1'b1;
          redir   = 1'b1;
          rpc     = mret_q ? (bus.mepc_i & ~XLEN'(1)) : (bus.mtvec_i & ~XLEN'(3));
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.csr_we_o      = we;
  assign bus.csr_idx_o     = idx;
  assign bus.csr_wdat_o    = wdat;
  assign bus.stall_o       = stall;
  assign bus.flush_o       = flush;
  assign bus.redirect_o    = redir;
  assign bus.redirect_pc_o = rpc;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Self-checking bench for csr_trap_seq: directed scenarios plus randomized requests
// checked cycle by cycle against an expected-trace model.
module tb_csr_trap_seq;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  csr_trap_seq_if #(.XLEN(32)) bus ();

  csr_trap_seq #(.XLEN(32), .IRQ_CODE(32'd11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] idx;
    logic [31:0] wdat;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic cyc_t mk(logic we, logic [11:0] idx, logic [31:0] wdat,
                              logic stall, logic flush, logic redir, logic [31:0] rpc);
    cyc_t c;
    c.we = we; c.idx = idx; c.wdat = wdat;
    c.stall = stall; c.flush = flush; c.redir = redir; c.rpc = rpc;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cyc(input string tag, input cyc_t e);
    check({tag, ".we"},    32'(bus.csr_we_o),   32'(e.we));
    check({tag, ".stall"}, 32'(bus.stall_o),    32'(e.stall));
    check({tag, ".flush"}, 32'(bus.flush_o),    32'(e.flush));
    check({tag, ".redir"}, 32'(bus.redirect_o), 32'(e.redir));
    check({tag, ".rpc"},   bus.redirect_pc_o,   e.rpc);
    check({tag, ".idx"},   32'(bus.csr_idx_o),  32'(e.idx));
    check({tag, ".wdat"},  bus.csr_wdat_o,      e.wdat);
  endtask

  task automatic clear_req();
    bus.exc_req_i = 1'b0;
    bus.irq_i     = 1'b0;
    bus.mret_i    = 1'b0;
    bus.pipe_we_i = 1'b0;
  endtask

  task automatic set_req(input logic exc, input logic irq, input logic mret, input logic pwe,
                         input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] ms,
                         input logic [31:0] tvec, input logic [31:0] epc,
                         input logic [11:0] pidx, input logic [31:0] pdat);
    bus.exc_req_i = exc;    bus.irq_i = irq;        bus.mret_i = mret;
    bus.pipe_we_i = pwe;    bus.exc_cause_i = cause; bus.pc_i = pc;
    bus.mstatus_i = ms;     bus.mtvec_i = tvec;     bus.mepc_i = epc;
    bus.pipe_idx_i = pidx;  bus.pipe_wdat_i = pdat;
  endtask

  // Expected trace derived from the architectural trap/MRET rules.
  task automatic model(input logic exc, input logic irq, input logic mret, input logic pwe,
                       input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] ms,
                       input logic [31:0] tvec, input logic [31:0] epc,
                       input logic [11:0] pidx, input logic [31:0] pdat);
    logic [31:0] mcause;
    exp_q.delete();
    if (exc || (irq && ms[3])) begin
      mcause = exc ? 32'(cause) : (32'h8000_0000 + 32'd11);
      exp_q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b1, 12'h341, pc & ~32'h1, 1'b1, 1'b0, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b1, 12'h342, mcause, 1'b1, 1'b0, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b1, 12'h300,
                         (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800,
                         1'b1, 1'b0, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b1, tvec & ~32'h3));
    end else if (mret) begin
      exp_q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b1, 12'h300,
                         (ms & ~32'h88) | (ms[7] ? 32'h8 : 32'h0) | 32'h1880,
                         1'b1, 1'b0, 1'b0, 32'h0));
      exp_q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b1, epc & ~32'h1));
    end else if (pwe) begin
      exp_q.push_back(mk(1'b1, pidx, pdat, 1'b0, 1'b0, 1'b0, 32'h0));
    end else begin
      exp_q.push_back(mk(1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    end
  endtask

  // Requests stay held through the sequence, then drop; the next cycle must be quiet.
  task automatic run_seq(input string tag);
    #1;
    foreach (exp_q[i]) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check_cyc($sformatf("%s.c%0d", tag, i), exp_q[i]);
    end
    @(posedge clk); #1;
    clear_req();
    #1;
    check_cyc({tag, ".idle"}, mk(1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  cyc_t zero;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    zero = mk(1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h8, 32'h0, 32'h0, 12'h341, 32'h1234);
    repeat (2) @(posedge clk);
    #1;
    check_cyc("reset", zero);
    clear_req();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: exception trap
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 32'h1c, 32'h8, 32'h81, 32'h0, 12'h0, 32'h0);
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 12'h000, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 12'h341, 32'h1c,   1'b1, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 12'h342, 32'h2,    1'b1, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 12'h300, 32'h1880, 1'b1, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b0, 12'h000, 32'h0,    1'b1, 1'b0, 1'b1, 32'h80));
    run_seq("t1");

    // 2: MRET
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h1880, 32'h0, 32'hffff_ffee, 12'h0, 32'h0);
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 12'h000, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 12'h300, 32'h1888, 1'b1, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b0, 12'h000, 32'h0,    1'b1, 1'b0, 1'b1, 32'hffff_ffee));
    run_seq("t2");

    // 3: masked IRQ stays quiet, then is taken once MIE is set
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h100, 32'h0, 12'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_cyc($sformatf("t3.masked%0d", i), zero);
      @(posedge clk); #1;
    end
    bus.mstatus_i = 32'h8;
    model(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h40, 32'h8, 32'h100, 32'h0, 12'h0, 32'h0);
    check("t3.mcause_model", exp_q[2].wdat, 32'h8000_000b);
    run_seq("t3");

    // 4: idle passthrough
    set_req(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 12'h341, 32'hffff_ffee);
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 12'h341, 32'hffff_ffee, 1'b0, 1'b0, 1'b0, 32'h0));
    run_seq("t4");

    // 5: exception wins over MRET and pipe write
    set_req(1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 32'h200, 32'h8, 32'h400, 32'h300, 12'h305, 32'hdead_beef);
    model(1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 32'h200, 32'h8, 32'h400, 32'h300, 12'h305, 32'hdead_beef);
    run_seq("t5");

    // 6: reset during W_CAUSE aborts the sequence
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 32'h88, 32'h8, 32'h500, 32'h0, 12'h0, 32'h0);
    #1;
    check_cyc("t6.c0", mk(1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
    @(posedge clk); #1;
    check_cyc("t6.c1", mk(1'b1, 12'h341, 32'h88, 1'b1, 1'b0, 1'b0, 32'h0));
    @(posedge clk); #1;
    check_cyc("t6.c2", mk(1'b1, 12'h342, 32'h7, 1'b1, 1'b0, 1'b0, 32'h0));
    reset = 1'b1;
    #1;
    check_cyc("t6.rst", zero);
    clear_req();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_cyc($sformatf("t6.after%0d", i), zero);
      @(posedge clk); #1;
    end

    // Randomized requests against the trace model
    for (int n = 0; n < 60; n++) begin
      logic        exc, irq, mret, pwe;
      logic [3:0]  cause;
      logic [31:0] pc, ms, tvec, epc, pdat;
      logic [11:0] pidx;
      exc   = ($urandom_range(0, 3) == 0);
      irq   = $urandom_range(0, 1) == 1;
      mret  = $urandom_range(0, 1) == 1;
      pwe   = $urandom_range(0, 1) == 1;
      cause = 4'($urandom);
      pc    = $urandom;
      ms    = $urandom;
      tvec  = $urandom;
      epc   = $urandom;
      pidx  = 12'($urandom);
      pdat  = $urandom;
      set_req(exc, irq, mret, pwe, cause, pc, ms, tvec, epc, pidx, pdat);
      model(exc, irq, mret, pwe, cause, pc, ms, tvec, epc, pidx, pdat);
      run_seq($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
